pipe_en_ctrl: RTL and testbench

//  Valid/ready sequencer for a Depth-stage datapath built from enable-register (Dffenr) stages.

---
 rtl/pipe_en_ctrl.sv | 83 ++++++++
 tb/tb_pipe_en_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_en_ctrl.sv
// pipe_en_ctrl: valid/ready sequencer for a Depth-stage enable-register datapath.
// It holds only a per-stage valid bit and an output-stall counter. Every load
// enable is derived combinationally from those valid bits and the handshake inputs.
module pipe_en_ctrl #(
    parameter  int Depth  = 4,
    parameter  int StallW = 16,
    localparam int OccW   = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              stall_clr_i,
    output logic [Depth-1:0]  en_o,
    output logic [OccW-1:0]   occ_o,
    output logic              idle_o,
    output logic [StallW-1:0] stall_cnt_o
);

    logic [Depth-1:0] v;       // stage k holds valid data
    logic [Depth-1:0] v_nxt;
    logic [Depth-1:0] iv;      // stage k input valid
    logic [Depth:0]   r;       // stage k may load (empty or draining)
    logic             run;     // no reset / flush / hold this cycle
    logic             stall_inc;

    assign run  = !rst_i && !flush_i && !hold_i;
    assign r[Depth] = m_ready_i;

    // Ready chain runs back from the sink and never looks at s_valid_i, so
    // s_ready_o has no combinational path from the upstream valid.
    for (genvar k = 0; k < Depth; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign iv[k] = s_valid_i;
        end else begin : g_rest
            assign iv[k] = v[k-1];
        end
        assign r[k]     = !v[k] || r[k+1];
        assign en_o[k]  = iv[k] && r[k] && run;
        // A stage stays full only while its successor cannot take its word.
        assign v_nxt[k] = en_o[k] || (v[k] && !r[k+1]);
    end

    assign s_ready_o = r[0] && run;
    // During reset the output still reflects the stored valid bit.
    // Hold and flush mask it so that no handshake can complete.
    assign m_valid_o = v[Depth-1] && (rst_i || (!flush_i && !hold_i));
    assign idle_o    = (v == '0);
    assign stall_inc = v[Depth-1] && !m_ready_i && run;

    // Valid-vector update: reset and flush empty the pipe, hold freezes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v <= '0;
        end else if (flush_i) begin
            v <= '0;
        end else if (!hold_i) begin
            v <= v_nxt;
        end
    end

    // Occupancy is the popcount of the valid vector.
    always_comb begin
        occ_o = '0;
        for (int k = 0; k < Depth; k++) begin
            occ_o = occ_o + OccW'(v[k]);
        end
    end

    // Saturating count of output-stall cycles; a clear beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || stall_clr_i) begin
            stall_cnt_o <= '0;
        end else if (stall_inc && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_en_ctrl.sv
// Directed and random checks for pipe_en_ctrl. Two instances share the same
// stimulus: a StallW=16 instance and a StallW=4 instance used to check saturation.
module tb_pipe_en_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic s_valid_i = 1'b0;
    logic m_ready_i = 1'b0;
    logic hold_i = 1'b0;
    logic flush_i = 1'b0;
    logic stall_clr_i = 1'b0;

    logic        s_ready_o, m_valid_o, idle_o;
    logic [3:0]  en_o;
    logic [2:0]  occ_o;
    logic [15:0] stall_cnt_o;

    logic        b_s_ready, b_m_valid, b_idle;
    logic [3:0]  b_en;
    logic [2:0]  b_occ;
    logic [3:0]  b_stall;

    int n_chk = 0;
    int n_fail = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    always #5 clk_i = ~clk_i;

    pipe_en_ctrl #(.Depth(4), .StallW(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .hold_i(hold_i), .flush_i(flush_i),
        .stall_clr_i(stall_clr_i), .en_o(en_o), .occ_o(occ_o), .idle_o(idle_o),
        .stall_cnt_o(stall_cnt_o)
    );

    pipe_en_ctrl #(.Depth(4), .StallW(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_ready_o(b_s_ready),
        .m_valid_o(b_m_valid), .m_ready_i(m_ready_i), .hold_i(hold_i), .flush_i(flush_i),
        .stall_clr_i(stall_clr_i), .en_o(b_en), .occ_o(b_occ), .idle_o(b_idle),
        .stall_cnt_o(b_stall)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Count handshakes seen in the current cycle, then advance to 1 after the next edge.
    task automatic step();
        #1;
        if (s_valid_i && s_ready_o) in_cnt++;
        if (m_valid_o && m_ready_i) out_cnt++;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int first_out;
        int sm;
        int exp_occ;
        bit exp_rdy;

        // Reset: nothing may be enabled or accepted while reset is asserted.
        rst_i = 1; s_valid_i = 1; m_ready_i = 1;
        @(posedge clk_i); #1;
        #1;
        chk("rst_en", en_o, 0);
        chk("rst_s_ready", s_ready_o, 0);
        step();
        rst_i = 0; s_valid_i = 0;
        #1;
        chk("post_rst_occ", occ_o, 0);
        chk("post_rst_idle", idle_o, 1);
        chk("post_rst_stall", stall_cnt_o, 0);
        chk("post_rst_en", en_o, 0);
        chk("post_rst_m_valid", m_valid_o, 0);
        chk("post_rst_s_ready", s_ready_o, 1);

        // Streaming from empty: latency of Depth cycles, then one word per cycle.
        for (int c = 0; c < 8; c++) begin
            s_valid_i = 1; m_ready_i = 1;
            #1;
            chk("fill_m_valid", m_valid_o, (c >= 4) ? 1 : 0);
            chk("fill_occ", occ_o, (c < 4) ? c : 4);
            chk("fill_en", en_o, (c >= 3) ? 15 : ((1 << (c + 1)) - 1));
            chk("fill_s_ready", s_ready_o, 1);
            step();
        end

        // Full and stalled for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            s_valid_i = 1; m_ready_i = 0;
            #1;
            chk("stall_s_ready", s_ready_o, 0);
            chk("stall_en", en_o, 0);
            chk("stall_m_valid", m_valid_o, 1);
            chk("stall_occ", occ_o, 4);
            step();
        end
        chk("stall_cnt10", stall_cnt_o, 10);
        chk("stall_cnt10_w4", b_stall, 10);
        for (int c = 0; c < 10; c++) step();
        chk("stall_cnt20", stall_cnt_o, 20);
        chk("stall_sat_w4", b_stall, 15);
        // The clear wins even though the stall condition is still present.
        stall_clr_i = 1;
        step();
        stall_clr_i = 0;
        #1;
        chk("stall_clr", stall_cnt_o, 0);
        chk("stall_clr_w4", b_stall, 0);

        // Drain one word to reach occ=3, then flush.
        s_valid_i = 0; m_ready_i = 1;
        step();
        chk("pre_flush_occ", occ_o, 3);
        flush_i = 1; s_valid_i = 1; m_ready_i = 1;
        #1;
        chk("flush_m_valid", m_valid_o, 0);
        chk("flush_s_ready", s_ready_o, 0);
        chk("flush_en", en_o, 0);
        step();
        flush_i = 0; s_valid_i = 0; m_ready_i = 0;
        #1;
        chk("post_flush_idle", idle_o, 1);
        chk("post_flush_occ", occ_o, 0);
        chk("post_flush_m_valid", m_valid_o, 0);
        chk("post_flush_s_ready", s_ready_o, 1);

        // Bubble collapse: words offered in cycles 0 and 3 with the sink stalled.
        for (int c = 0; c < 7; c++) begin
            s_valid_i = (c == 0 || c == 3);
            m_ready_i = 0;
            #1;
            if (c == 3) chk("bubble_s_ready", s_ready_o, 1);
            step();
        end
        s_valid_i = 0;
        #1;
        chk("bubble_occ", occ_o, 2);
        chk("bubble_en", en_o, 0);
        chk("bubble_m_valid", m_valid_o, 1);
        chk("bubble_s_ready", s_ready_o, 1);
        m_ready_i = 1;
        step();
        step();
        chk("bubble_drain_idle", idle_o, 1);

        // Hold for cycles 3..7 while six words stream through.
        in_cnt = 0; out_cnt = 0; first_out = -1;
        for (int c = 0; c < 30; c++) begin
            s_valid_i = (in_cnt < 6);
            m_ready_i = 1;
            hold_i = (c >= 3 && c < 8);
            #1;
            if (hold_i) begin
                chk("hold_en", en_o, 0);
                chk("hold_s_ready", s_ready_o, 0);
                chk("hold_m_valid", m_valid_o, 0);
                chk("hold_occ", occ_o, 3);
            end
            if (m_valid_o && m_ready_i && first_out < 0) first_out = c;
            step();
        end
        hold_i = 0; s_valid_i = 0;
        chk("hold_first_out", first_out, 9);
        chk("hold_in_cnt", in_cnt, 6);
        chk("hold_out_cnt", out_cnt, 6);
        chk("hold_idle", idle_o, 1);

        // Reset mid-stream discards the in-flight words and the stall count.
        for (int c = 0; c < 3; c++) begin
            s_valid_i = 1; m_ready_i = 0;
            step();
        end
        chk("pre_rst_occ", occ_o, 3);
        rst_i = 1;
        #1;
        chk("mid_rst_en", en_o, 0);
        chk("mid_rst_s_ready", s_ready_o, 0);
        step();
        rst_i = 0; s_valid_i = 0;
        #1;
        chk("mid_rst_idle", idle_o, 1);
        chk("mid_rst_occ", occ_o, 0);
        chk("mid_rst_stall", b_stall, 0);

        // Random traffic: conservation of words, the ready rule and the saturating stall count.
        in_cnt = 0; out_cnt = 0; sm = 0;
        for (int c = 0; c < 10000; c++) begin
            s_valid_i = 1'($urandom_range(0, 1));
            m_ready_i = (c < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            hold_i = ($urandom_range(0, 15) == 0);
            #1;
            exp_occ = in_cnt - out_cnt;
            exp_rdy = !hold_i && ((exp_occ < 4) || m_ready_i);
            chk("rand_occ", occ_o, exp_occ);
            chk("rand_s_ready", s_ready_o, exp_rdy);
            chk("rand_stall_w4", b_stall, sm);
            if (m_valid_o && !m_ready_i && !hold_i && sm < 15) sm++;
            step();
        end
        hold_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
